ahb_lite_apb_bridge: RTL and testbench

//  AHB-lite slave that converts single AHB transfers into APB4 accesses.

---
 rtl/ahb_lite_apb_bridge_pkg.sv | 26 ++
 rtl/ahb_lite_apb_bridge_strb.sv | 31 +++
 rtl/ahb_lite_apb_bridge.sv | 188 ++++++++++++++++++
 tb/tb_ahb_lite_apb_bridge.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_lite_apb_bridge_pkg.sv
// Shared encodings for the AHB-lite to APB4 bridge: response codes, transfer
// sizes, bridge FSM states and the HPROT->PPROT mapping.
package ahb_lite_apb_bridge_pkg;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  localparam logic [2:0] HSIZE_BYTE = 3'b000;
  localparam logic [2:0] HSIZE_HALF = 3'b001;
  localparam logic [2:0] HSIZE_WORD = 3'b010;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WCAP,
    ST_SETUP,
    ST_ACCESS,
    ST_ERR1,
    ST_ERR2
  } state_t;

  // APB privilege follows HPROT[1]; APB instruction bit is the inverse of HPROT[0] (data)
  function automatic logic [2:0] pprot_f(input logic [3:0] hprot);
    return {~hprot[0], 1'b1, hprot[1]};
  endfunction

endpackage

// File: rtl/ahb_lite_apb_bridge_strb.sv
// Combinational byte-strobe generation and alignment check for one AHB address phase.
// Strobes are forced to zero for reads.
module ahb_lite_apb_bridge_strb
  import ahb_lite_apb_bridge_pkg::*;
(
  input  logic [2:0] hsize_i,
  input  logic [1:0] addr_i,
  input  logic       hwrite_i,
  output logic [3:0] strb_o,
  output logic       illegal_o
);

  always_comb begin
    strb_o    = 4'h0;
    illegal_o = 1'b0;
    case (hsize_i)
      HSIZE_BYTE: strb_o = 4'b0001 << addr_i;
      HSIZE_HALF: begin
        strb_o    = 4'b0011 << {addr_i[1], 1'b0};
        illegal_o = addr_i[0];
      end
      HSIZE_WORD: begin
        strb_o    = 4'hF;
        illegal_o = |addr_i;
      end
      default: illegal_o = 1'b1;
    endcase
    if (!hwrite_i) strb_o = 4'h0;
  end

endmodule

// File: rtl/ahb_lite_apb_bridge.sv
// AHB-lite slave turning single transfers into APB4 accesses, one at a time, with
// registered outputs and a two-cycle ERROR for PSLVERR, timeout or illegal transfers.
module ahb_lite_apb_bridge
  import ahb_lite_apb_bridge_pkg::*;
#(
  parameter int P_ADDR_WIDTH = 16,
  parameter int P_TIMEOUT    = 0
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL,
  input  logic [31:0]             HADDR,
  input  logic [1:0]              HTRANS,
  input  logic                    HWRITE,
  input  logic [2:0]              HSIZE,
  input  logic [2:0]              HBURST,
  input  logic [3:0]              HPROT,
  input  logic [31:0]             HWDATA,
  input  logic                    HREADY,
  output logic [31:0]             HRDATA,
  output logic [1:0]              HRESP,
  output logic                    HREADYout,
  output logic [P_ADDR_WIDTH-1:0] PADDR,
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [31:0]             PWDATA,
  output logic [3:0]              PSTRB,
  output logic [2:0]              PPROT,
  input  logic [31:0]             PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int CW = (P_TIMEOUT < 2) ? 1 : $clog2(P_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(P_TIMEOUT - 1);

  state_t                  state_q, state_d;
  logic [31:0]             hrdata_q, hrdata_d;
  logic [1:0]              hresp_q, hresp_d;
  logic                    hready_q, hready_d;
  logic [P_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic                    psel_q, psel_d;
  logic                    penable_q, penable_d;
  logic                    pwrite_q, pwrite_d;
  logic [31:0]             pwdata_q, pwdata_d;
  logic [3:0]              pstrb_q, pstrb_d;
  logic [2:0]              pprot_q, pprot_d;
  logic [CW-1:0]           cnt_q, cnt_d;

  logic       acc;
  logic       illegal;
  logic [3:0] strb;
  logic       timeout_hit;
  logic       unused_ok;

  assign unused_ok = ^{HBURST, HPROT[3:2], HTRANS[0], HADDR};

  ahb_lite_apb_bridge_strb u_strb (
    .hsize_i   (HSIZE),
    .addr_i    (HADDR[1:0]),
    .hwrite_i  (HWRITE),
    .strb_o    (strb),
    .illegal_o (illegal)
  );

  assign acc         = HSEL & HREADY & HTRANS[1] & hready_q;
  assign timeout_hit = (P_TIMEOUT != 0) && (cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    hrdata_d  = hrdata_q;
    hresp_d   = hresp_q;
    hready_d  = hready_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pwdata_d  = pwdata_q;
    pstrb_d   = pstrb_q;
    pprot_d   = pprot_q;
    cnt_d     = cnt_q;
    case (state_q)
      // ERR2 is the HREADYout=1 half of an error, so it may accept a new transfer
      ST_IDLE, ST_ERR2: begin
        if (acc) begin
          hready_d = 1'b0;
          if (illegal) begin
            hresp_d = HRESP_ERROR;
            state_d = ST_ERR1;
          end else begin
            hresp_d  = HRESP_OKAY;
            paddr_d  = HADDR[P_ADDR_WIDTH-1:0];
            pwrite_d = HWRITE;
            pstrb_d  = strb;
            pprot_d  = pprot_f(HPROT);
            if (HWRITE) begin
              state_d = ST_WCAP;
            end else begin
              psel_d  = 1'b1;
              state_d = ST_SETUP;
            end
          end
        end else begin
          hready_d = 1'b1;
          hresp_d  = HRESP_OKAY;
          state_d  = ST_IDLE;
        end
      end
      ST_WCAP: begin
        pwdata_d = HWDATA;
        psel_d   = 1'b1;
        state_d  = ST_SETUP;
      end
      ST_SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ST_ACCESS;
      end
      ST_ACCESS: begin
        if (PREADY || timeout_hit) begin
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (!PREADY || PSLVERR) begin
            hready_d = 1'b0;
            hresp_d  = HRESP_ERROR;
            state_d  = ST_ERR1;
          end else begin
            if (!pwrite_q) hrdata_d = PRDATA;
            hready_d = 1'b1;
            hresp_d  = HRESP_OKAY;
            state_d  = ST_IDLE;
          end
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_ERR1: begin
        hready_d = 1'b1;
        hresp_d  = HRESP_ERROR;
        state_d  = ST_ERR2;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= ST_IDLE;
      hrdata_q  <= '0;
      hresp_q   <= HRESP_OKAY;
      hready_q  <= 1'b1;
      paddr_q   <= '0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pwdata_q  <= '0;
      pstrb_q   <= '0;
      pprot_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      hrdata_q  <= hrdata_d;
      hresp_q   <= hresp_d;
      hready_q  <= hready_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pwdata_q  <= pwdata_d;
      pstrb_q   <= pstrb_d;
      pprot_q   <= pprot_d;
      cnt_q     <= cnt_d;
    end
  end

  assign HRDATA    = hrdata_q;
  assign HRESP     = hresp_q;
  assign HREADYout = hready_q;
  assign PADDR     = paddr_q;
  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign PPROT     = pprot_q;

endmodule

// File: tb/tb_ahb_lite_apb_bridge.sv
// Bench for ahb_lite_apb_bridge: one instance without timeout, one with P_TIMEOUT=4,
// driven by directed and random single transfers against a transaction-level model.
module tb_ahb_lite_apb_bridge;

  logic        clk = 1'b0;
  logic        hreset;
  logic        hsel, use4;
  logic [31:0] haddr, hwdata, prdata;
  logic [1:0]  htrans;
  logic        hwrite, pready, pslverr;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;

  logic [31:0] hrdata0, hrdata4, pwdata0, pwdata4;
  logic [1:0]  hresp0, hresp4;
  logic        hro0, hro4, psel0, psel4, pen0, pen4, pwr0, pwr4;
  logic [15:0] paddr0, paddr4;
  logic [3:0]  pstrb0, pstrb4;
  logic [2:0]  pprot0, pprot4;

  logic        hready_bus;
  logic [31:0] o_hrdata, o_pwdata;
  logic [1:0]  o_hresp;
  logic        o_hro, o_psel, o_pen, o_pwr;
  logic [15:0] o_paddr;
  logic [3:0]  o_pstrb;
  logic [2:0]  o_pprot;

  assign hready_bus = use4 ? hro4 : hro0;
  assign o_hrdata   = use4 ? hrdata4 : hrdata0;
  assign o_pwdata   = use4 ? pwdata4 : pwdata0;
  assign o_hresp    = use4 ? hresp4 : hresp0;
  assign o_hro      = use4 ? hro4 : hro0;
  assign o_psel     = use4 ? psel4 : psel0;
  assign o_pen      = use4 ? pen4 : pen0;
  assign o_pwr      = use4 ? pwr4 : pwr0;
  assign o_paddr    = use4 ? paddr4 : paddr0;
  assign o_pstrb    = use4 ? pstrb4 : pstrb0;
  assign o_pprot    = use4 ? pprot4 : pprot0;

  always #5 clk = ~clk;

  ahb_lite_apb_bridge #(.P_ADDR_WIDTH(16), .P_TIMEOUT(0)) dut0 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & ~use4), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(hrdata0), .HRESP(hresp0), .HREADYout(hro0),
    .PADDR(paddr0), .PSEL(psel0), .PENABLE(pen0), .PWRITE(pwr0), .PWDATA(pwdata0),
    .PSTRB(pstrb0), .PPROT(pprot0), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  ahb_lite_apb_bridge #(.P_ADDR_WIDTH(16), .P_TIMEOUT(4)) dut4 (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel & use4), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot), .HWDATA(hwdata),
    .HREADY(hready_bus), .HRDATA(hrdata4), .HRESP(hresp4), .HREADYout(hro4),
    .PADDR(paddr4), .PSEL(psel4), .PENABLE(pen4), .PWRITE(pwr4), .PWDATA(pwdata4),
    .PSTRB(pstrb4), .PPROT(pprot4), .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
  );

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_hrdata [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit m_illegal(input logic [2:0] size, input logic [31:0] addr);
    if (size > 3'd2) return 1'b1;
    return (addr % (32'd1 << size)) != 32'd0;
  endfunction

  function automatic logic [3:0] m_strb(input logic wr, input logic [2:0] size,
                                        input logic [31:0] addr);
    int nb, base;
    if (!wr) return 4'h0;
    nb   = 1 << size;
    base = int'(addr % 32'd4);
    return 4'(((1 << nb) - 1) << base);
  endfunction

  task automatic idle(input int n);
    hsel   = 1'b0;
    htrans = 2'b00;
    pready = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // One AHB transfer on the chosen instance, playing the APB slave: PREADY stays low
  // for 'low' ACCESS cycles, then rises with PSLVERR='err'. Ends in the HREADYout=1 cycle.
  task automatic xfer(input string tag, input bit t4, input logic [31:0] addr, input logic wr,
                      input logic [2:0] size, input logic [3:0] prot, input logic [31:0] wdata,
                      input int low, input logic err, input logic [31:0] rdata);
    bit          illegal, tmo, fail;
    int          exp_acc, exp_waits, waits, acc_cyc, setup_cyc, errw;
    logic [1:0]  resp_last;
    illegal   = m_illegal(size, addr);
    tmo       = t4 && (low >= 4);
    exp_acc   = illegal ? 0 : (tmo ? 4 : low + 1);
    fail      = illegal || err || tmo;
    exp_waits = illegal ? 1 : (wr ? 1 : 0) + 1 + exp_acc + (fail ? 1 : 0);

    use4   = t4;
    hsel   = 1'b1;
    htrans = 2'b10;
    haddr  = addr;
    hwrite = wr;
    hsize  = size;
    hprot  = prot;
    hburst = 3'($urandom_range(0, 7));
    @(posedge clk); #1;
    hsel   = 1'b0;
    htrans = 2'b00;
    haddr  = $urandom;
    hwrite = 1'($urandom);
    hwdata = wdata;

    waits = 0; acc_cyc = 0; setup_cyc = 0; errw = 0; resp_last = 2'b00;
    for (int c = 0; c < 64 && o_hro !== 1'b1; c++) begin
      if (o_psel === 1'b1 && o_pen === 1'b0) begin
        setup_cyc++;
        check({tag, ".paddr"}, 32'(o_paddr), 32'(addr[15:0]));
        check({tag, ".pwrite"}, 32'(o_pwr), 32'(wr));
        check({tag, ".pstrb"}, 32'(o_pstrb), 32'(m_strb(wr, size, addr)));
        check({tag, ".pprot"}, 32'(o_pprot), 32'({~prot[0], 1'b1, prot[1]}));
        if (wr) check({tag, ".pwdata"}, o_pwdata, wdata);
      end
      if (o_psel === 1'b1 && o_pen === 1'b1) begin
        acc_cyc++;
        if (acc_cyc > low) begin
          pready  = 1'b1;
          pslverr = err;
          prdata  = rdata;
        end else begin
          pready  = 1'b0;
          pslverr = 1'($urandom);
          prdata  = $urandom;
        end
      end else begin
        pready  = 1'($urandom);
        pslverr = 1'($urandom);
      end
      if (o_hresp !== 2'b00) errw++;
      resp_last = o_hresp;
      waits++;
      @(posedge clk); #1;
    end
    pready  = 1'b0;
    pslverr = 1'b0;

    check({tag, ".done"}, 32'(o_hro), 32'd1);
    check({tag, ".waits"}, 32'(waits), 32'(exp_waits));
    check({tag, ".access_cycles"}, 32'(acc_cyc), 32'(exp_acc));
    check({tag, ".setup_cycles"}, 32'(setup_cyc), illegal ? 32'd0 : 32'd1);
    check({tag, ".err_wait_cycles"}, 32'(errw), fail ? 32'd1 : 32'd0);
    check({tag, ".last_wait_resp"}, 32'(resp_last), fail ? 32'd1 : 32'd0);
    check({tag, ".hresp"}, 32'(o_hresp), fail ? 32'd1 : 32'd0);
    check({tag, ".psel_end"}, 32'(o_psel), 32'd0);
    check({tag, ".penable_end"}, 32'(o_pen), 32'd0);
    if (!fail && !wr) m_hrdata[t4] = rdata;
    check({tag, ".hrdata"}, o_hrdata, m_hrdata[t4]);
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; use4 = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'b000; hburst = 3'b000; hprot = 4'h0; hwdata = '0; prdata = '0;
    pready = 1'b0; pslverr = 1'b0;
    m_hrdata[0] = '0;
    m_hrdata[1] = '0;
    repeat (3) @(posedge clk);
    #1;

    check("rst.hreadyout0", 32'(hro0), 32'd1);
    check("rst.hresp0", 32'(hresp0), 32'd0);
    check("rst.hrdata0", hrdata0, 32'd0);
    check("rst.psel0", 32'(psel0), 32'd0);
    check("rst.penable0", 32'(pen0), 32'd0);
    check("rst.pwrite0", 32'(pwr0), 32'd0);
    check("rst.paddr0", 32'(paddr0), 32'd0);
    check("rst.pwdata0", pwdata0, 32'd0);
    check("rst.pstrb0", 32'(pstrb0), 32'd0);
    check("rst.pprot0", 32'(pprot0), 32'd0);
    check("rst.hreadyout4", 32'(hro4), 32'd1);
    check("rst.psel4", 32'(psel4), 32'd0);
    hreset = 1'b0;
    @(posedge clk); #1;

    xfer("rd104", 1'b0, 32'h0000_0104, 1'b0, 3'b010, 4'h3, 32'h0, 0, 1'b0, 32'hCAFE_F00D);
    xfer("wrbyte203", 1'b0, 32'h0000_0203, 1'b1, 3'b000, 4'h1, 32'h1122_3344, 0, 1'b0, 32'h0);
    xfer("slverr", 1'b0, 32'h0000_0040, 1'b0, 3'b010, 4'h2, 32'h0, 5, 1'b1, 32'h5555_AAAA);
    idle(1);
    check("err2_idle.hresp", 32'(o_hresp), 32'd0);
    check("err2_idle.hreadyout", 32'(o_hro), 32'd1);

    xfer("misaligned", 1'b0, 32'h0000_1002, 1'b0, 3'b010, 4'h0, 32'h0, 0, 1'b0, 32'h0);
    xfer("b2b_in_err2", 1'b0, 32'h0000_2008, 1'b0, 3'b010, 4'h0, 32'h0, 1, 1'b0, 32'h0BAD_BEEF);
    xfer("b2b_okay", 1'b0, 32'h0000_300E, 1'b1, 3'b001, 4'h3, 32'hA5A5_5A5A, 2, 1'b0, 32'h0);
    idle(1);

    hsel = 1'b1; htrans = 2'b01; haddr = 32'h0000_0102; hsize = 3'b010; hwrite = 1'b0;
    @(posedge clk); #1;
    check("busy.hreadyout", 32'(o_hro), 32'd1);
    check("busy.hresp", 32'(o_hresp), 32'd0);
    check("busy.psel", 32'(o_psel), 32'd0);
    idle(1);

    use4 = 1'b1;
    xfer("timeout", 1'b1, 32'h0000_0044, 1'b0, 3'b010, 4'h0, 32'h0, 100, 1'b0, 32'h0);
    idle(1);
    check("timeout_idle.hresp", 32'(o_hresp), 32'd0);
    xfer("t4_late_ok", 1'b1, 32'h0000_0048, 1'b0, 3'b010, 4'h0, 32'h0, 3, 1'b0, 32'h1234_5678);
    idle(1);

    use4 = 1'b0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0300; hwrite = 1'b0; hsize = 3'b010;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; pready = 1'b0;
    for (int c = 0; c < 8 && o_pen !== 1'b1; c++) begin
      @(posedge clk); #1;
    end
    check("rst_access.penable_before", 32'(o_pen), 32'd1);
    hreset = 1'b1;
    #1;
    check("rst_access.psel", 32'(o_psel), 32'd0);
    check("rst_access.penable", 32'(o_pen), 32'd0);
    @(posedge clk); #1;
    hreset = 1'b0;
    m_hrdata[0] = '0;
    m_hrdata[1] = '0;
    @(posedge clk); #1;
    check("rst_release.hreadyout", 32'(o_hro), 32'd1);
    check("rst_release.hresp", 32'(o_hresp), 32'd0);
    check("rst_release.psel", 32'(o_psel), 32'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] a;
      logic [2:0]  sz;
      bit          t4;
      t4 = ($urandom_range(0, 3) == 0);
      a  = $urandom;
      sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << (sz > 3'd2 ? 3'd0 : sz)) - 32'd1);
      if (t4 != use4) idle(1);
      xfer($sformatf("rnd%0d", i), t4, a, 1'($urandom), sz, 4'($urandom), $urandom,
           $urandom_range(0, t4 ? 6 : 3), ($urandom_range(0, 4) == 0), $urandom);
      if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
    end
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
